// File: rtl/ex3_5_if.sv
// Operand/result bundle for the ex3_5 four-operand signed adder.
// The master drives operands and the overflow clear; the slave returns registered results.
interface ex3_5_if;
  logic              in_valid;
  logic signed [3:0] A;
  logic signed [3:0] B;
  logic signed [3:0] C;
  logic signed [3:0] D;
  logic              ovf_clear;
  logic signed [3:0] sum;
  logic              overflow;
  logic signed [5:0] sum_full;
  logic              out_valid;
  logic              ovf_sticky;

  modport master (
    output in_valid, A, B, C, D, ovf_clear,
    input  sum, overflow, sum_full, out_valid, ovf_sticky
  );

  modport slave (
    input  in_valid, A, B, C, D, ovf_clear,
    output sum, overflow, sum_full, out_valid, ovf_sticky
  );
endinterface

// File: rtl/ex3_5.sv
// Registered four-operand 4-bit signed adder with exact 6-bit sum, overflow and sticky overflow.
// Optional macro SATURATE_EN clamps the 4-bit sum to 7 / -8 instead of wrapping.
module ex3_5 (
  input logic   clk,
  input logic   rst,
  ex3_5_if.slave bus
);

  localparam logic signed [5:0] SUM_MAX = 6'sd7;
  localparam logic signed [5:0] SUM_MIN = -6'sd8;

  logic signed [5:0] exact;
  logic              ovf_next;
  logic signed [3:0] sum_next;

  // All operands are widened first, so only the final sum can be out of range.
  assign exact = {{2{bus.A[3]}}, bus.A} + {{2{bus.B[3]}}, bus.B}
               + {{2{bus.C[3]}}, bus.C} + {{2{bus.D[3]}}, bus.D};

  assign ovf_next = (exact > SUM_MAX) || (exact < SUM_MIN);

`ifdef SATURATE_EN
  always_comb begin
    sum_next = exact[3:0];
    if (exact > SUM_MAX)
      sum_next = 4'sd7;
    else if (exact < SUM_MIN)
      sum_next = -4'sd8;
  end
`else
  assign sum_next = exact[3:0];
`endif

  // Results hold while in_valid is low; a new overflow beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sum        <= '0;
      bus.sum_full   <= '0;
      bus.overflow   <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.ovf_sticky <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.sum      <= sum_next;
        bus.sum_full <= exact;
        bus.overflow <= ovf_next;
      end
      if (bus.in_valid && ovf_next)
        bus.ovf_sticky <= 1'b1;
      else if (bus.ovf_clear)
        bus.ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex3_5.sv
// Self-checking bench for ex3_5: integer reference model compared every cycle,
// plus directed vectors with literal expectations.
module tb_ex3_5;

  logic clk;
  logic rst;
  int   assert_count;
  int   fail_count;

  ex3_5_if bus ();

  ex3_5 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, written only by the model process.
  bit model_live;
  int m_sum;
  int m_full;
  int m_ovf;
  int m_valid;
  int m_sticky;

  function automatic int expected_sum(input int e);
    int w;
`ifdef SATURATE_EN
    if (e > 7) return 7;
    if (e < -8) return -8;
    return e;
`else
    w = ((e % 16) + 16) % 16;
    if (w > 7) w = w - 16;
    return w;
`endif
  endfunction

  always @(posedge clk) begin
    int e;
    int o;
    e = int'(bus.A) + int'(bus.B) + int'(bus.C) + int'(bus.D);
    o = (e > 7 || e < -8) ? 1 : 0;
    if (rst) begin
      model_live = 1'b1;
      m_sum = 0; m_full = 0; m_ovf = 0; m_valid = 0; m_sticky = 0;
    end else if (model_live) begin
      m_valid = bus.in_valid ? 1 : 0;
      if (bus.in_valid) begin
        m_sum  = expected_sum(e);
        m_full = e;
        m_ovf  = o;
      end
      if (bus.in_valid && o == 1)
        m_sticky = 1;
      else if (bus.ovf_clear)
        m_sticky = 0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model, once a reset has been seen.
  always @(posedge clk) begin
    #2;
    if (model_live) begin
      checkOutput("model.sum",        int'(bus.sum),        m_sum);
      checkOutput("model.sum_full",   int'(bus.sum_full),   m_full);
      checkOutput("model.overflow",   int'(bus.overflow),   m_ovf);
      checkOutput("model.out_valid",  int'(bus.out_valid),  m_valid);
      checkOutput("model.ovf_sticky", int'(bus.ovf_sticky), m_sticky);
    end
  end

  task automatic applyStimulus(input int a, input int b, input int c, input int d,
                               input bit valid, input bit clr, input bit rst_in);
    @(negedge clk);
    bus.A         = 4'(a);
    bus.B         = 4'(b);
    bus.C         = 4'(c);
    bus.D         = 4'(d);
    bus.in_valid  = valid;
    bus.ovf_clear = clr;
    rst           = rst_in;
    @(posedge clk);
    #3;
  endtask

  initial begin
    int held_sum;
    assert_count = 0;
    fail_count   = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.ovf_clear = 1'b0;
    bus.A = '0; bus.B = '0; bus.C = '0; bus.D = '0;

    applyStimulus(7, 7, 7, 7, 1, 0, 1);
    applyStimulus(7, 7, 7, 7, 1, 1, 1);
    checkOutput("rst.sum",        int'(bus.sum),        0);
    checkOutput("rst.sum_full",   int'(bus.sum_full),   0);
    checkOutput("rst.overflow",   int'(bus.overflow),   0);
    checkOutput("rst.out_valid",  int'(bus.out_valid),  0);
    checkOutput("rst.ovf_sticky", int'(bus.ovf_sticky), 0);

    applyStimulus(3, 2, -1, 1, 1, 0, 0);
    checkOutput("v1.sum",       int'(bus.sum),       5);
    checkOutput("v1.sum_full",  int'(bus.sum_full),  5);
    checkOutput("v1.overflow",  int'(bus.overflow),  0);
    checkOutput("v1.out_valid", int'(bus.out_valid), 1);

    applyStimulus(7, 4, 3, -2, 1, 0, 0);
    checkOutput("v2.sum_full",   int'(bus.sum_full),   12);
    checkOutput("v2.overflow",   int'(bus.overflow),   1);
    checkOutput("v2.ovf_sticky", int'(bus.ovf_sticky), 1);
`ifdef SATURATE_EN
    checkOutput("v2.sum", int'(bus.sum), 7);
`else
    checkOutput("v2.sum", int'(bus.sum), -4);
`endif
    held_sum = int'(bus.sum);

    applyStimulus(1, 1, 1, 1, 0, 0, 0);
    checkOutput("hold.sum",       int'(bus.sum),       held_sum);
    checkOutput("hold.sum_full",  int'(bus.sum_full),  12);
    checkOutput("hold.overflow",  int'(bus.overflow),  1);
    checkOutput("hold.out_valid", int'(bus.out_valid), 0);

    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    checkOutput("clr.sum",        int'(bus.sum),        0);
    checkOutput("clr.overflow",   int'(bus.overflow),   0);
    checkOutput("clr.ovf_sticky", int'(bus.ovf_sticky), 0);

    applyStimulus(-8, -4, -1, 7, 1, 0, 0);
    checkOutput("v3.sum",        int'(bus.sum),        -6);
    checkOutput("v3.overflow",   int'(bus.overflow),   0);
    checkOutput("v3.ovf_sticky", int'(bus.ovf_sticky), 0);

    applyStimulus(-6, -3, -2, -1, 1, 0, 0);
    checkOutput("v4.sum_full",  int'(bus.sum_full), -12);
    checkOutput("v4.overflow",  int'(bus.overflow), 1);
`ifdef SATURATE_EN
    checkOutput("v4.sum", int'(bus.sum), -8);
`else
    checkOutput("v4.sum", int'(bus.sum), 4);
`endif

    applyStimulus(7, 4, 3, -2, 1, 1, 0);
    checkOutput("setwins.ovf_sticky", int'(bus.ovf_sticky), 1);

    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("idleclr.ovf_sticky", int'(bus.ovf_sticky), 0);
    checkOutput("idleclr.out_valid",  int'(bus.out_valid),  0);

    applyStimulus(7, 0, 0, 0, 1, 0, 0);
    checkOutput("edge7.overflow", int'(bus.overflow), 0);
    applyStimulus(-8, 0, 0, 0, 1, 0, 0);
    checkOutput("edgem8.overflow", int'(bus.overflow), 0);
    checkOutput("edgem8.sum",      int'(bus.sum),      -8);
    applyStimulus(4, 4, 0, 0, 1, 0, 0);
    checkOutput("edge8.overflow", int'(bus.overflow), 1);
    checkOutput("edge8.sum_full", int'(bus.sum_full), 8);
    applyStimulus(-8, -8, -8, -8, 1, 0, 0);
    checkOutput("min.sum_full", int'(bus.sum_full), -32);
`ifdef SATURATE_EN
    checkOutput("min.sum", int'(bus.sum), -8);
`else
    checkOutput("min.sum", int'(bus.sum), 0);
`endif
    applyStimulus(7, 7, 7, 7, 1, 0, 0);
    checkOutput("max.sum_full", int'(bus.sum_full), 28);
`ifdef SATURATE_EN
    checkOutput("max.sum", int'(bus.sum), 7);
`else
    checkOutput("max.sum", int'(bus.sum), -4);
`endif

    // Back-to-back traffic with occasional gaps and clears, checked by the model.
    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom_range(15) - 8, $urandom_range(15) - 8,
                    $urandom_range(15) - 8, $urandom_range(15) - 8,
                    ($urandom_range(4) != 0), ($urandom_range(5) == 0), 1'b0);
    end

    applyStimulus(7, 7, 7, 7, 1, 0, 1);
    checkOutput("rst2.sum_full",   int'(bus.sum_full),   0);
    checkOutput("rst2.ovf_sticky", int'(bus.ovf_sticky), 0);
    applyStimulus(1, 1, 1, 1, 1, 0, 0);
    checkOutput("post_rst.sum",       int'(bus.sum),       4);
    checkOutput("post_rst.out_valid", int'(bus.out_valid), 1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
